// File: rtl/snn_net_sequencer.sv
// -----------------------------------------------------------------------------
// snn_net_sequencer
//
// Purpose:
//   Programs the spiking XOR network through its addr/cmd/cmd_arg bus from a
//   small on-chip weight table, then samples the network output. Each accepted
//   start runs one fixed sequence:
//     network reset -> replay every table slot (drive, then one idle gap)
//     -> settle for SETTLE_CYCLES -> sample net_out -> report with done.
//
// Optional feature (compile-time macro):
//   SNN_SEQ_CHECK_EN  When defined, result is compared against the expected
//                     value latched with start; mismatch flags the difference
//                     and err_cnt counts mismatches (saturating at 255).
//                     When undefined, mismatch and err_cnt are tied to 0 and
//                     the expected input is ignored.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   tbl_we/tbl_idx/...    table write port; tbl_drop pulses for a rejected write
//   start, in1, in2       run request and network inputs for the run
//   expected              expected network output, sampled with start
//   busy, done, result    run status, one-cycle completion pulse, sampled out
//   mismatch, err_cnt     compare result and saturating mismatch count
//   net_rst               active-high reset to the network
//   net_addr/cmd/arg      network programming bus (addr all-ones = idle)
//   net_in1, net_in2      network inputs, held from start to next start
//   net_out               network output
// -----------------------------------------------------------------------------
module snn_net_sequencer #(
  parameter int INT_WIDTH     = 4,
  parameter int FLOAT_WIDTH   = 2 * INT_WIDTH,
  parameter int ADDR_WIDTH    = 3,
  parameter int CMD_WIDTH     = 3,
  parameter int NUM_WEIGHTS   = 6,
  parameter int SETTLE_CYCLES = 25,
  localparam int IDX_WIDTH    = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,

  input  logic                   tbl_we,
  input  logic [IDX_WIDTH-1:0]   tbl_idx,
  input  logic [ADDR_WIDTH-1:0]  tbl_addr,
  input  logic [CMD_WIDTH-1:0]   tbl_cmd,
  input  logic [FLOAT_WIDTH-1:0] tbl_weight,
  output logic                   tbl_drop,

  input  logic                   start,
  input  logic                   in1,
  input  logic                   in2,
  input  logic                   expected,
  output logic                   busy,
  output logic                   done,
  output logic                   result,
  output logic                   mismatch,
  output logic [7:0]             err_cnt,

  output logic                   net_rst,
  output logic [ADDR_WIDTH-1:0]  net_addr,
  output logic [CMD_WIDTH-1:0]   net_cmd,
  output logic [FLOAT_WIDTH-1:0] net_arg,
  output logic                   net_in1,
  output logic                   net_in2,
  input  logic                   net_out
);

  localparam int CNT_WIDTH = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [ADDR_WIDTH-1:0] IDLE_ADDR   = '1;
  localparam logic [IDX_WIDTH-1:0]  LAST_IDX    = IDX_WIDTH'(NUM_WEIGHTS - 1);
  localparam logic [IDX_WIDTH:0]    NUM_SLOTS   = (IDX_WIDTH + 1)'(NUM_WEIGHTS);
  localparam logic [CNT_WIDTH-1:0]  SETTLE_LAST = CNT_WIDTH'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_NRST,
    S_DRIVE,
    S_GAP,
    S_SETTLE,
    S_SAMPLE
  } state_t;

  state_t                 state;
  logic [IDX_WIDTH-1:0]   idx;
  logic [CNT_WIDTH-1:0]   settle_cnt;

  // ---------------------------------------------------------------------------
  // Weight table. Payload lives in plain arrays (no reset) so it can map to
  // distributed/block memory; only the valid bits need clearing on reset.
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0]  mem_addr   [NUM_WEIGHTS];
  logic [CMD_WIDTH-1:0]   mem_cmd    [NUM_WEIGHTS];
  logic [FLOAT_WIDTH-1:0] mem_weight [NUM_WEIGHTS];
  logic [NUM_WEIGHTS-1:0] valid;

  logic idx_in_range;
  logic wr_ok;

  assign idx_in_range = ({1'b0, tbl_idx} < NUM_SLOTS);
  // busy is the registered run flag, so a write on the accepting edge still
  // lands and the run that starts on that edge sees the new entry.
  assign wr_ok        = tbl_we && !busy && idx_in_range;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_addr[tbl_idx]   <= tbl_addr;
      mem_cmd[tbl_idx]    <= tbl_cmd;
      mem_weight[tbl_idx] <= tbl_weight;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (wr_ok) begin
      valid[tbl_idx] <= 1'b1;
    end
  end

  // Slot to place on the bus at the next edge: slot 0 when leaving NRST,
  // the following slot when leaving a GAP. The read data is registered
  // straight into the bus outputs.
  logic [IDX_WIDTH-1:0]   rd_idx;
  logic                   rd_valid;
  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic [CMD_WIDTH-1:0]   rd_cmd;
  logic [FLOAT_WIDTH-1:0] rd_weight;

  always_comb begin
    rd_idx = '0;
    if (state == S_GAP) begin
      rd_idx = idx + 1'b1;
    end
  end

  assign rd_valid  = valid[rd_idx];
  assign rd_addr   = mem_addr[rd_idx];
  assign rd_cmd    = mem_cmd[rd_idx];
  assign rd_weight = mem_weight[rd_idx];

`ifdef SNN_SEQ_CHECK_EN
  logic expected_reg;
`else
  logic unused_expected;
  assign unused_expected = expected;
  assign mismatch        = 1'b0;
  assign err_cnt         = 8'd0;
`endif

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= 1'b0;
      tbl_drop   <= 1'b0;
      net_rst    <= 1'b1;
      net_addr   <= IDLE_ADDR;
      net_cmd    <= '0;
      net_arg    <= '0;
      net_in1    <= 1'b0;
      net_in2    <= 1'b0;
`ifdef SNN_SEQ_CHECK_EN
      expected_reg <= 1'b0;
      mismatch     <= 1'b0;
      err_cnt      <= 8'd0;
`endif
    end else begin
      done     <= 1'b0;
      net_rst  <= 1'b0;
      tbl_drop <= tbl_we && (busy || !idx_in_range);

      case (state)
        S_IDLE: begin
          // A start coinciding with the done pulse is deliberately dropped.
          if (start && !done) begin
            net_in1 <= in1;
            net_in2 <= in2;
`ifdef SNN_SEQ_CHECK_EN
            expected_reg <= expected;
`endif
            net_rst <= 1'b1;
            busy    <= 1'b1;
            state   <= S_NRST;
          end
        end

        S_NRST: begin
          idx      <= '0;
          net_addr <= rd_valid ? rd_addr : IDLE_ADDR;
          net_cmd  <= rd_valid ? rd_cmd : '0;
          net_arg  <= rd_valid ? rd_weight : '0;
          state    <= S_DRIVE;
        end

        S_DRIVE: begin
          net_addr <= IDLE_ADDR;
          net_cmd  <= '0;
          net_arg  <= '0;
          state    <= S_GAP;
        end

        S_GAP: begin
          if (idx == LAST_IDX) begin
            settle_cnt <= '0;
            state      <= S_SETTLE;
          end else begin
            idx      <= idx + 1'b1;
            net_addr <= rd_valid ? rd_addr : IDLE_ADDR;
            net_cmd  <= rd_valid ? rd_cmd : '0;
            net_arg  <= rd_valid ? rd_weight : '0;
            state    <= S_DRIVE;
          end
        end

        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= S_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        S_SAMPLE: begin
          result <= net_out;
          done   <= 1'b1;
          busy   <= 1'b0;
`ifdef SNN_SEQ_CHECK_EN
          mismatch <= (net_out != expected_reg);
          if ((net_out != expected_reg) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
          end
`endif
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snn_net_sequencer.sv
// -----------------------------------------------------------------------------
// tb_snn_net_sequencer
//
// Directed bench for snn_net_sequencer. A small stand-in for the XOR network
// captures bus writes after each net_rst and only produces in1^in2 when it has
// received exactly the six reference weights in slot order; otherwise it
// outputs 0.
// -----------------------------------------------------------------------------
module tb_snn_net_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tbl_we = 1'b0;
  logic [2:0] tbl_idx = '0;
  logic [2:0] tbl_addr = '0;
  logic [2:0] tbl_cmd = '0;
  logic [7:0] tbl_weight = '0;
  logic       tbl_drop;
  logic       start = 1'b0;
  logic       in1 = 1'b0;
  logic       in2 = 1'b0;
  logic       expected = 1'b0;
  logic       busy;
  logic       done;
  logic       result;
  logic       mismatch;
  logic [7:0] err_cnt;
  logic       net_rst;
  logic [2:0] net_addr;
  logic [2:0] net_cmd;
  logic [7:0] net_arg;
  logic       net_in1;
  logic       net_in2;
  logic       net_out;

  int vectors = 0;
  int miscompares = 0;

  always #10 clk = ~clk;

  snn_net_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tbl_we     (tbl_we),
    .tbl_idx    (tbl_idx),
    .tbl_addr   (tbl_addr),
    .tbl_cmd    (tbl_cmd),
    .tbl_weight (tbl_weight),
    .tbl_drop   (tbl_drop),
    .start      (start),
    .in1        (in1),
    .in2        (in2),
    .expected   (expected),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .mismatch   (mismatch),
    .err_cnt    (err_cnt),
    .net_rst    (net_rst),
    .net_addr   (net_addr),
    .net_cmd    (net_cmd),
    .net_arg    (net_arg),
    .net_in1    (net_in1),
    .net_in2    (net_in2),
    .net_out    (net_out)
  );

  // Reference XOR weight set.
  logic [2:0] ref_addr [6] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3};
  logic [2:0] ref_cmd  [6] = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd1, 3'd2};
  logic [7:0] ref_w    [6] = '{8'h07, 8'h07, 8'h12, 8'h12, 8'hF1, 8'h0F};

  // Stand-in network.
  int   cap_cnt;
  logic cap_ok;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || net_rst) begin
      cap_cnt <= 0;
      cap_ok  <= 1'b1;
    end else if (net_addr != 3'd7) begin
      if (cap_cnt >= 6) begin
        cap_ok <= 1'b0;
      end else if (net_addr != ref_addr[cap_cnt] || net_cmd != ref_cmd[cap_cnt] ||
                   net_arg != ref_w[cap_cnt]) begin
        cap_ok <= 1'b0;
      end
      cap_cnt <= cap_cnt + 1;
    end
  end

  always_comb begin
    net_out = 1'b0;
    if (cap_cnt == 6 && cap_ok) net_out = net_in1 ^ net_in2;
  end

  // Per-run log, index = cycle after the accepting edge.
  logic [2:0] lg_addr [0:80];
  logic [2:0] lg_cmd  [0:80];
  logic [7:0] lg_arg  [0:80];
  logic       lg_rst  [0:80];
  logic       lg_busy [0:80];
  logic       lg_drop [0:80];
  int         lat;
  logic       r_result;
  logic       r_mis;
  logic [7:0] r_err;

  task automatic write_entry(input int i, input logic [2:0] a, input logic [2:0] c,
                             input logic [7:0] w);
    @(negedge clk);
    tbl_we = 1'b1; tbl_idx = 3'(i); tbl_addr = a; tbl_cmd = c; tbl_weight = w;
    @(posedge clk); #1;
    tbl_we = 1'b0;
  endtask

  // One run; if inj >= 1, a start and a table write to slot 0 are driven
  // during cycle inj (mid-run).
  task automatic do_run(input logic a, input logic b, input logic e, input int inj);
    bit got;
    @(negedge clk);
    in1 = a; in2 = b; expected = e; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lg_addr[0] = net_addr; lg_cmd[0] = net_cmd; lg_arg[0] = net_arg;
    lg_rst[0] = net_rst; lg_busy[0] = busy; lg_drop[0] = tbl_drop;
    lat = -1;
    got = 0;
    for (int c = 1; c <= 80 && !got; c++) begin
      @(posedge clk); #1;
      if (c == inj + 1) begin start = 1'b0; tbl_we = 1'b0; end
      lg_addr[c] = net_addr; lg_cmd[c] = net_cmd; lg_arg[c] = net_arg;
      lg_rst[c] = net_rst; lg_busy[c] = busy; lg_drop[c] = tbl_drop;
      if (done) begin
        got = 1; lat = c; r_result = result; r_mis = mismatch; r_err = err_cnt;
      end
      if (c == inj) begin
        start = 1'b1; tbl_we = 1'b1; tbl_idx = 3'd0;
        tbl_addr = 3'd5; tbl_cmd = 3'd5; tbl_weight = 8'h55;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (net_rst !== 1'b1 || net_addr !== 3'd7 || net_cmd !== 3'd0 || net_arg !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_bus: rst=%b addr=%0d cmd=%0d arg=%0d, want 1/7/0/0",
               net_rst, net_addr, net_cmd, net_arg);
    end
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || tbl_drop !== 1'b0 || result !== 1'b0 ||
        net_in1 !== 1'b0 || net_in2 !== 1'b0 || mismatch !== 1'b0 || err_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_status: busy=%b done=%b drop=%b res=%b in=%b%b mis=%b err=%0d, want all 0",
               busy, done, tbl_drop, result, net_in1, net_in2, mismatch, err_cnt);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (net_rst !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: net_rst=%b, want 0", net_rst);
    end
    $display("reset: checked");
  endtask

  task automatic test_load;
    for (int i = 0; i < 6; i++) begin
      write_entry(i, ref_addr[i], ref_cmd[i], ref_w[i]);
      vectors++;
      if (tbl_drop !== 1'b0) begin
        miscompares++;
        $display("FAIL load_drop slot %0d: tbl_drop=%b, want 0", i, tbl_drop);
      end
    end
    write_entry(6, 3'd4, 3'd4, 8'h44);
    vectors++;
    if (tbl_drop !== 1'b1) begin
      miscompares++;
      $display("FAIL range_drop: tbl_drop=%b, want 1", tbl_drop);
    end
    @(posedge clk); #1;
    vectors++;
    if (tbl_drop !== 1'b0) begin
      miscompares++;
      $display("FAIL range_drop_pulse: tbl_drop=%b, want 0", tbl_drop);
    end
    $display("load: table written, out-of-range slot rejected");
  endtask

  task automatic test_xor_runs;
    logic [1:0] pat;
    logic       want;
    for (int p = 0; p < 4; p++) begin
      pat = 2'(p);
      want = pat[1] ^ pat[0];
      do_run(pat[1], pat[0], want, -1);
      vectors++;
      if (lat !== 39) begin
        miscompares++;
        $display("FAIL xor_latency in=%b: got %0d, want 39", pat, lat);
      end
      vectors++;
      if (r_result !== want) begin
        miscompares++;
        $display("FAIL xor_result in=%b: got %b, want %b", pat, r_result, want);
      end
      vectors++;
      if (r_mis !== 1'b0 || r_err !== 8'd0) begin
        miscompares++;
        $display("FAIL xor_check in=%b: mismatch=%b err_cnt=%0d, want 0/0", pat, r_mis, r_err);
      end
      vectors++;
      if (net_in1 !== pat[1] || net_in2 !== pat[0]) begin
        miscompares++;
        $display("FAIL xor_inputs in=%b: net_in=%b%b", pat, net_in1, net_in2);
      end
      $display("xor run in=%b: result=%b latency=%0d", pat, r_result, lat);
    end
  endtask

  task automatic test_bus_monitor;
    int k;
    do_run(1'b1, 1'b0, 1'b1, -1);
    vectors++;
    if (lg_rst[0] !== 1'b1 || lg_rst[1] !== 1'b0 || lg_busy[0] !== 1'b1 || lg_addr[0] !== 3'd7) begin
      miscompares++;
      $display("FAIL bus_nrst: rst c0=%b c1=%b busy=%b addr=%0d, want 1/0/1/7",
               lg_rst[0], lg_rst[1], lg_busy[0], lg_addr[0]);
    end
    for (int c = 1; c <= 38; c++) begin
      k = (c - 1) / 2;
      vectors++;
      if (c <= 12 && (c % 2) == 1) begin
        if (lg_addr[c] !== ref_addr[k] || lg_cmd[c] !== ref_cmd[k] || lg_arg[c] !== ref_w[k]) begin
          miscompares++;
          $display("FAIL bus_write cycle %0d: %0d/%0d/%h, want %0d/%0d/%h", c,
                   lg_addr[c], lg_cmd[c], lg_arg[c], ref_addr[k], ref_cmd[k], ref_w[k]);
        end
      end else if (lg_addr[c] !== 3'd7 || lg_cmd[c] !== 3'd0 || lg_arg[c] !== 8'd0 ||
                   lg_busy[c] !== 1'b1) begin
        miscompares++;
        $display("FAIL bus_idle cycle %0d: %0d/%0d/%h busy=%b, want 7/0/00 busy=1", c,
                 lg_addr[c], lg_cmd[c], lg_arg[c], lg_busy[c]);
      end
    end
    vectors++;
    if (lg_busy[39] !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_drop: busy=%b with done, want 0", lg_busy[39]);
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (net_addr !== 3'd7 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL bus_quiet cycle %0d: addr=%0d busy=%b, want 7/0", c, net_addr, busy);
      end
    end
    $display("bus monitor: six writes in slot order checked");
  endtask

  task automatic test_back_to_back;
    bit got;
    @(negedge clk);
    in1 = 1'b0; in2 = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got = 0;
    for (int c = 1; c <= 80 && !got; c++) begin
      @(posedge clk); #1;
      if (done) got = 1;
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL b2b_done: no done within 80 cycles");
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_ignore: busy=%b after start with done, want 0", busy);
    end
    $display("back to back: start during done ignored");
  endtask

  task automatic test_busy_protection;
    bit extra;
    do_run(1'b0, 1'b1, 1'b1, 20);
    vectors++;
    if (lg_drop[21] !== 1'b1 || lg_drop[22] !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_drop_pulse: drop c21=%b c22=%b, want 1/0", lg_drop[21], lg_drop[22]);
    end
    vectors++;
    if (lat !== 39 || r_result !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_run: latency=%0d result=%b, want 39/1", lat, r_result);
    end
    extra = 0;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk); #1;
      if (done || busy) extra = 1;
    end
    vectors++;
    if (extra) begin
      miscompares++;
      $display("FAIL busy_start_queued: activity after run, want none");
    end
    do_run(1'b0, 1'b1, 1'b1, -1);
    vectors++;
    if (lg_addr[1] !== 3'd1 || lg_arg[1] !== 8'h07 || r_result !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_table_kept: slot0 %0d/%h result=%b, want 1/07/1",
               lg_addr[1], lg_arg[1], r_result);
    end
    $display("busy protection: mid-run start and write rejected");
  endtask

  task automatic test_check;
`ifdef SNN_SEQ_CHECK_EN
    do_run(1'b0, 1'b0, 1'b1, -1);
    vectors++;
    if (r_mis !== 1'b1 || r_err !== 8'd1) begin
      miscompares++;
      $display("FAIL check_first: mismatch=%b err_cnt=%0d, want 1/1", r_mis, r_err);
    end
    for (int i = 1; i < 300; i++) do_run(1'b0, 1'b0, 1'b1, -1);
    vectors++;
    if (r_err !== 8'd255 || r_mis !== 1'b1) begin
      miscompares++;
      $display("FAIL check_saturate: err_cnt=%0d mismatch=%b, want 255/1", r_err, r_mis);
    end
    $display("check: 300 mismatching runs, err_cnt=%0d", r_err);
`else
    do_run(1'b0, 1'b0, 1'b1, -1);
    vectors++;
    if (r_mis !== 1'b0 || r_err !== 8'd0) begin
      miscompares++;
      $display("FAIL check_off: mismatch=%b err_cnt=%0d, want 0/0", r_mis, r_err);
    end
    $display("check: compare disabled, mismatch=%b", r_mis);
`endif
  endtask

  task automatic test_empty_slot;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i != 3) write_entry(i, ref_addr[i], ref_cmd[i], ref_w[i]);
    end
    do_run(1'b0, 1'b1, 1'b1, -1);
    vectors++;
    if (lg_addr[7] !== 3'd7) begin
      miscompares++;
      $display("FAIL empty_slot: cycle 7 addr=%0d, want 7", lg_addr[7]);
    end
    vectors++;
    if (lg_addr[9] !== 3'd3 || lg_arg[9] !== 8'hF1) begin
      miscompares++;
      $display("FAIL empty_next: cycle 9 %0d/%h, want 3/F1", lg_addr[9], lg_arg[9]);
    end
    vectors++;
    if (lat !== 39 || r_result !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_run: latency=%0d result=%b, want 39/0", lat, r_result);
    end
    $display("empty slot: latency=%0d", lat);
  endtask

  task automatic test_reset_mid_run;
    bit wrote;
    @(negedge clk);
    in1 = 1'b1; in2 = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || net_rst !== 1'b1 || net_addr !== 3'd7 || net_in1 !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_reset: busy=%b rst=%b addr=%0d in1=%b, want 0/1/7/0",
               busy, net_rst, net_addr, net_in1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (net_rst !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_release: net_rst=%b busy=%b, want 0/0", net_rst, busy);
    end
    do_run(1'b1, 1'b0, 1'b1, -1);
    wrote = 0;
    for (int c = 0; c <= 39; c++) if (lg_addr[c] !== 3'd7) wrote = 1;
    vectors++;
    if (wrote) begin
      miscompares++;
      $display("FAIL midrun_table: bus writes seen after reset, want none");
    end
    vectors++;
    if (lat !== 39 || r_result !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_run: latency=%0d result=%b, want 39/0", lat, r_result);
    end
    $display("reset mid-run: table cleared, latency=%0d", lat);
  endtask

  initial begin
    test_reset;
    test_load;
    test_xor_runs;
    test_bus_monitor;
    test_back_to_back;
    test_busy_protection;
    test_check;
    test_empty_slot;
    test_reset_mid_run;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/snn_net_sequencer.md
# snn_net_sequencer

Hardware initiator for the spiking network's weight-programming bus (`addr`/`cmd`/`cmd_arg`) and its `in1`/`in2`/`out` pins. It replaces the bench-side programming procedure with synthesizable control: it holds a small weight table, and on each `start` it runs one fixed sequence:

- resets the network,
- replays every table entry onto the bus,
- waits a fixed settle time,
- samples `out` and reports it with `done`.

It sits between a host/controller and `spiking_neural_network_xor`.

## Interface
- `INT_WIDTH`, 4, integer width of the network.
- `FLOAT_WIDTH`, 2*INT_WIDTH, signed weight width (`cmd_arg`).
- `ADDR_WIDTH`, 3, network neuron address width; all-ones means idle.
- `CMD_WIDTH`, 3, network command width.
- `NUM_WEIGHTS`, 6, weight table depth.
- `SETTLE_CYCLES`, 25, cycles between the last bus write and sampling `out`; must be ≥1.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `tbl_we` in 1: table write strobe.
- `tbl_idx` in $clog2(NUM_WEIGHTS): table slot.
- `tbl_addr` in ADDR_WIDTH: neuron address to store.
- `tbl_cmd` in CMD_WIDTH: command to store.
- `tbl_weight` in FLOAT_WIDTH: signed weight to store.
- `tbl_drop` out 1: one-cycle pulse when a table write is rejected.
- `start` in 1: run request.
- `in1`, `in2` in 1: network inputs for this run.
- `expected` in 1: expected output; sampled with `start`.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle pulse when `result` is valid.
- `result` out 1: sampled network `out`.
- `mismatch` out 1: `result` differs from `expected`; valid with `done`.
- `err_cnt` out 8: saturating count of mismatches.
- `net_rst` out 1: active-high reset to the network.
- `net_addr` out ADDR_WIDTH: drives the network `addr`.
- `net_cmd` out CMD_WIDTH: drives the network `cmd`.
- `net_arg` out FLOAT_WIDTH: drives the network `cmd_arg`.
- `net_in1`, `net_in2` out 1: drive the network inputs.
- `net_out` in 1: network `out`.

## Operation
- **Table:** NUM_WEIGHTS entries, each {valid, addr, cmd, weight}.
  - `tbl_we` while `busy` is 0 writes slot `tbl_idx` and sets its valid bit.
  - `tbl_we` while `busy` is 1, or with `tbl_idx` ≥ NUM_WEIGHTS, leaves the table unchanged and pulses `tbl_drop` on the next cycle.
- **States:** IDLE → NRST → DRIVE ⇄ GAP → SETTLE → SAMPLE → IDLE.
- **IDLE:** `start` is accepted when in IDLE.
  - Latches `in1`/`in2` onto `net_in1`/`net_in2` and latches `expected`.
  - Moves to NRST.
- **NRST:** `net_rst` = 1 for exactly one cycle; index ← 0.
- **DRIVE:** for a valid entry, drive its addr/cmd/weight onto `net_addr`/`net_cmd`/`net_arg` for one cycle. For an invalid entry, keep `net_addr` all-ones (no write); the cycle is still spent.
- **GAP:** `net_addr` = all-ones, `net_cmd` = 0, `net_arg` = 0 for one cycle.
  - Increment the index.
  - After the last entry, go to SETTLE; otherwise go to DRIVE.
- **SETTLE:** count SETTLE_CYCLES with the bus idle.
- **SAMPLE:** register `net_out` into `result`, compute `mismatch`, pulse `done`, return to IDLE.
- **Ignored requests:** `start` while `busy` is ignored and not queued. `start` in the same cycle as `done` is also ignored.
- **Simultaneous `tbl_we` and `start` in IDLE:** the write happens and the run uses the new value.
- **Run-stable signals:** `net_in1`/`net_in2` hold from `start` until the next accepted `start`. `result` and `mismatch` hold until the next `done`.
- **Reset (`rst_n` low, any time, including mid-run):**
  - Table valid bits cleared; state forced to IDLE.
  - `busy`, `done`, `result`, `mismatch`, `tbl_drop` = 0; `err_cnt` = 0.
  - `net_rst` = 1.
  - `net_addr` = all-ones; `net_cmd` and `net_arg` = 0.
  - `net_in1` and `net_in2` = 0.
  - On the first edge after release, `net_rst` drops to 0.

## Timing
- The edge that accepts `start` is edge 0.
- `busy` is high from after edge 0 until after edge 2*NUM_WEIGHTS+SETTLE_CYCLES+2. It drops in the same cycle that `done` rises.
- `net_rst` is high between edges 0 and 1.
- Entry k is on the bus between edges 1+2k and 2+2k. The following GAP cycle is between edges 2+2k and 3+2k.
- `net_out` is sampled at edge 2*NUM_WEIGHTS+SETTLE_CYCLES+2.
- `done` is high for one cycle after that edge.
- With defaults, `done` follows start by 39 cycles (780 ns at a 20 ns clock).
- All outputs are registered.

## Configuration
- Macro: `SNN_SEQ_CHECK_EN`.
- **Defined:** `mismatch` = (`result` != latched `expected`) at `done`; `err_cnt` increments on each mismatch and saturates at 255.
- **Undefined:** no compare or counter logic is built; `mismatch` and `err_cnt` are tied to 0. The `expected` port remains present and is ignored.

## Test plan
- **Reset values:** hold `rst_n` = 0 → `net_rst` = 1, `net_addr` = 7, `net_cmd` = 0, `net_arg` = 0, `busy` = 0, `done` = 0. Release → `net_rst` = 0 after the first edge.
- **XOR runs:**
  - Load (1,1,7), (1,2,7), (2,1,18), (2,2,18), (3,1,-15), (3,2,15) into slots 0–5.
  - Run `start` with (`in1`,`in2`) = 00, 01, 10, 11 → `result` = 0, 1, 1, 0.
  - Each `done` arrives exactly 39 cycles after its `start`.
  - `mismatch` = 0; `err_cnt` = 0.
- **Bus monitor:** during a run the bus shows exactly six non-idle writes, one cycle each, in slot order, each separated by one idle cycle with `net_addr` = 7. No bus activity occurs outside a run.
- **Empty table / busy protection:** start with slot 3 never written → no write on the bus in cycle 7, but latency is still 39. `start` and `tbl_we` issued mid-run → `start` ignored, table unchanged, `tbl_drop` pulses once.
- **Reset mid-run:** assert `rst_n` = 0 during SETTLE → `busy` = 0 and all table entries invalid. After release, a new run produces no bus writes and `done` arrives at 39 cycles.
- **`SNN_SEQ_CHECK_EN` defined:** run XOR with `expected` = 1 for inputs 00 → `mismatch` = 1, `err_cnt` = 1. Repeat 300 times → `err_cnt` = 255.
